regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameters: ADDR_W, default 4, write address width; DATA_W, default 8, write data width; DEPTH, default 16, number of registers cleared.
REQ-002 Clock and reset are fixed: one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  single clock, all state on posedge.
REQ-004 reset_n  input  1  synchronous active-low reset.
REQ-005 reqValid0 / reqValid1  input  1  requester 0/1 write request valid.
REQ-006 reqReady0 / reqReady1  output  1  requester 0/1 request accepted this cycle.
REQ-007 reqAddress0 / reqAddress1  input  ADDR_W  target register.
REQ-008 reqData0 / reqData1  input  DATA_W  write data.
REQ-009 clearStart  input  1  one-cycle pulse, zero all registers.
REQ-010 clearBusy  output  1  clear sequence in progress.
REQ-011 writeAddress  output  ADDR_W  register file write address.
REQ-012 writeData  output  DATA_W  register file write data.
REQ-013 writeEnable  output  1  register file write strobe.
REQ-014 grantId  output  1  requester owning the current writeEnable cycle.
REQ-015 conflictCount  output  8  saturating count of cycles with both requests valid and no clear active.

Function
REQ-016 States: IDLE, CLEAR; reset enters IDLE.
REQ-017 In IDLE with clearStart low: one request accepted per cycle; handshake completes when reqValidN and reqReadyN are both high.
REQ-018 Round-robin: sole valid requester wins; if both valid, the requester not granted last wins; lastGrant updates only on accept.
REQ-019 reqReadyN may depend combinationally on both reqValid inputs and clearStart; requesters shall not make reqValid depend on reqReady.
REQ-020 Latency: accepted request drives writeEnable=1 with its address, data and grantId on the next cycle; otherwise writeEnable=0, with writeAddress/writeData holding their last values.
REQ-021 clearStart in IDLE: both readies low that cycle; next state CLEAR with clear counter 0.
REQ-022 CLEAR: each cycle writes register counter with data 0 (writeEnable=1 on the following cycle); counter increments; after DEPTH-1 is issued, returns to IDLE.
REQ-023 clearBusy high from the cycle after clearStart until the cycle after the last clear write is issued; both readies low throughout.
REQ-024 clearStart while in CLEAR is ignored; no restart.
REQ-025 conflictCount increments on each IDLE cycle with both valid and clearStart low; saturates at 255.

Reset
REQ-026 reset_n low at posedge: state IDLE, writeEnable 0, writeAddress 0, writeData 0, grantId 0, clearBusy 0, conflictCount 0, counter 0, lastGrant 1 (requester 0 wins first tie).
REQ-027 Reset during CLEAR aborts the sequence; no further clear writes issue.

Configuration
REQ-028 Macro RF_ARB_ZERO_REG_EN defined: accepted requests to address 0 complete the handshake but produce writeEnable=0; clear writes to address 0 still issue.
REQ-029 Macro undefined: address 0 is written like any other register.

Structure
REQ-030 Package rf_pkg holds RF_ADDR_W=4, RF_DATA_W=8, RF_DEPTH=16 and the state enum typedef arb_state_t.
REQ-031 Sub-module rr_arbiter2: combinational two-way round-robin grant from valids and lastGrant.

Verification
REQ-032 After reset, reqValid0=1 addr 3 data 0x5A, reqValid1=0 -> reqReady0=1; next cycle writeEnable=1, writeAddress=3, writeData=0x5A, grantId=0.
REQ-033 Both valid for 4 cycles -> grants alternate 0,1,0,1; conflictCount=4.
REQ-034 clearStart pulse -> clearBusy high 16 cycles; writes to addresses 0..15 with data 0; readies low throughout.
REQ-035 clearStart and reqValid0 in the same IDLE cycle -> reqReady0=0; clear proceeds; request accepted after clearBusy falls.
REQ-036 reset_n low at clear counter 7 -> no writes follow; clearBusy=0; IDLE.
REQ-037 With RF_ARB_ZERO_REG_EN, request addr 0 data 0xFF -> reqReady0=1, writeEnable stays 0; without the macro -> writeEnable=1, writeAddress=0, writeData=0xFF.

Source files
------------

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared widths, depth and FSM state type for the regfile write arbiter
package rf_pkg;
  localparam int RF_ADDR_W = 4;
  localparam int RF_DATA_W = 8;
  localparam int RF_DEPTH  = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } arb_state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - combinational two-way round-robin grant
module rr_arbiter2 (
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_last_grant,
  output logic o_grant0,
  output logic o_grant1
);

  // On a tie the requester that did not win last time takes the grant.
  assign o_grant0 = i_valid0 & (~i_valid1 | i_last_grant);
  assign o_grant1 = i_valid1 & (~i_valid0 | ~i_last_grant);

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-requester register file write arbiter with clear sequence
// Optional: RF_ARB_ZERO_REG_EN suppresses request writes to address 0.
module regfile_write_arbiter
  import rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W,
  parameter int DEPTH  = RF_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              reqValid0,
  output logic              reqReady0,
  input  logic [ADDR_W-1:0] reqAddress0,
  input  logic [DATA_W-1:0] reqData0,
  input  logic              reqValid1,
  output logic              reqReady1,
  input  logic [ADDR_W-1:0] reqAddress1,
  input  logic [DATA_W-1:0] reqData1,
  input  logic              clearStart,
  output logic              clearBusy,
  output logic [ADDR_W-1:0] writeAddress,
  output logic [DATA_W-1:0] writeData,
  output logic              writeEnable,
  output logic              grantId,
  output logic [7:0]        conflictCount
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  arb_state_t        r_state;
  arb_state_t        w_next_state;
  logic [ADDR_W-1:0] r_counter;
  logic              r_last_grant;

  logic              w_arb_en;
  logic              w_clear_issue;
  logic              w_grant0;
  logic              w_grant1;
  logic              w_accept;
  logic              w_sel_id;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_zero_block;

  rr_arbiter2 u_rr_arbiter2 (
    .i_valid0     (reqValid0),
    .i_valid1     (reqValid1),
    .i_last_grant (r_last_grant),
    .o_grant0     (w_grant0),
    .o_grant1     (w_grant1)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_arb_en      = 1'b0;
    w_clear_issue = 1'b0;
    case (r_state)
      IDLE: begin
        if (clearStart) begin
          w_next_state = CLEAR;
        end else begin
          w_arb_en = 1'b1;
        end
      end
      CLEAR: begin
        w_clear_issue = 1'b1;
        if (r_counter == LAST_IDX) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign reqReady0  = w_arb_en & w_grant0;
  assign reqReady1  = w_arb_en & w_grant1;
  assign w_accept   = reqReady0 | reqReady1;
  assign w_sel_id   = reqReady1;
  assign w_sel_addr = reqReady1 ? reqAddress1 : reqAddress0;
  assign w_sel_data = reqReady1 ? reqData1 : reqData0;
  assign clearBusy  = (r_state == CLEAR);

`ifdef RF_ARB_ZERO_REG_EN
  assign w_zero_block = (w_sel_addr == '0);
`else
  assign w_zero_block = 1'b0;
`endif

  // Address/data/grantId hold their last values on cycles without a write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      writeEnable   <= 1'b0;
      writeAddress  <= '0;
      writeData     <= '0;
      grantId       <= 1'b0;
      conflictCount <= 8'd0;
      r_counter     <= '0;
      r_last_grant  <= 1'b1;
    end else begin
      writeEnable <= 1'b0;
      if (w_clear_issue) begin
        writeEnable  <= 1'b1;
        writeAddress <= r_counter;
        writeData    <= '0;
        r_counter    <= (r_counter == LAST_IDX) ? '0 : r_counter + 1'b1;
      end else if (r_state == IDLE && clearStart) begin
        r_counter <= '0;
      end else if (w_accept) begin
        r_last_grant <= w_sel_id;
        if (!w_zero_block) begin
          writeEnable  <= 1'b1;
          writeAddress <= w_sel_addr;
          writeData    <= w_sel_data;
          grantId      <= w_sel_id;
        end
      end
      if (w_arb_en && reqValid0 && reqValid1 && conflictCount != 8'hFF) begin
        conflictCount <= conflictCount + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       reqValid0 = 1'b0, reqValid1 = 1'b0;
  logic       reqReady0, reqReady1;
  logic [3:0] reqAddress0 = '0, reqAddress1 = '0;
  logic [7:0] reqData0 = '0, reqData1 = '0;
  logic       clearStart = 1'b0;
  logic       clearBusy;
  logic [3:0] writeAddress;
  logic [7:0] writeData;
  logic       writeEnable;
  logic       grantId;
  logic [7:0] conflictCount;

  regfile_write_arbiter dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .reqValid0     (reqValid0),
    .reqReady0     (reqReady0),
    .reqAddress0   (reqAddress0),
    .reqData0      (reqData0),
    .reqValid1     (reqValid1),
    .reqReady1     (reqReady1),
    .reqAddress1   (reqAddress1),
    .reqData1      (reqData1),
    .clearStart    (clearStart),
    .clearBusy     (clearBusy),
    .writeAddress  (writeAddress),
    .writeData     (writeData),
    .writeEnable   (writeEnable),
    .grantId       (grantId),
    .conflictCount (conflictCount)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: pending clear writes, round-robin memory, expected outputs.
  int         m_left;
  int         m_idx;
  logic       m_last;
  int         m_conf;
  logic       m_we;
  logic [3:0] m_wa;
  logic [7:0] m_wd;
  logic       m_gid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_left = 0;
    m_idx  = 0;
    m_last = 1'b1;
    m_conf = 0;
    m_we   = 1'b0;
    m_wa   = '0;
    m_wd   = '0;
    m_gid  = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".we"}, writeEnable, m_we);
    chk({tag, ".wa"}, writeAddress, m_wa);
    chk({tag, ".wd"}, writeData, m_wd);
    chk({tag, ".gid"}, grantId, m_gid);
    chk({tag, ".busy"}, clearBusy, m_left > 0);
    chk({tag, ".conf"}, conflictCount, m_conf);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    reqValid0 = 1'b0;
    reqValid1 = 1'b0;
    clearStart = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic step(input logic v0, input logic [3:0] a0, input logic [7:0] d0,
                      input logic v1, input logic [3:0] a1, input logic [7:0] d1,
                      input logic cs, input string tag);
    logic e_r0, e_r1, have, win;
    logic [3:0] a;
    logic [7:0] d;
    @(negedge clk);
    reqValid0 = v0; reqAddress0 = a0; reqData0 = d0;
    reqValid1 = v1; reqAddress1 = a1; reqData1 = d1;
    clearStart = cs;
    #1;
    e_r0 = 1'b0;
    e_r1 = 1'b0;
    chk({tag, ".busy_pre"}, clearBusy, m_left > 0);
    if (m_left > 0) begin
      m_we = 1'b1;
      m_wa = 4'(m_idx);
      m_wd = 8'h00;
      m_idx++;
      m_left--;
    end else if (cs) begin
      m_we   = 1'b0;
      m_left = DEPTH;
      m_idx  = 0;
    end else begin
      have = v0 | v1;
      if (v0 && v1) begin
        win = ~m_last;
        if (m_conf < 255) m_conf++;
      end else begin
        win = v1;
      end
      m_we = 1'b0;
      if (have) begin
        e_r0   = (win == 1'b0);
        e_r1   = (win == 1'b1);
        m_last = win;
        a = win ? a1 : a0;
        d = win ? d1 : d0;
`ifdef RF_ARB_ZERO_REG_EN
        if (a != 4'd0) begin
`else
        begin
`endif
          m_we  = 1'b1;
          m_wa  = a;
          m_wd  = d;
          m_gid = win;
        end
      end
    end
    chk({tag, ".rdy0"}, reqReady0, e_r0);
    chk({tag, ".rdy1"}, reqReady1, e_r1);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_cycles;
    int clear_writes;
    logic [3:0] gids;

    model_reset();
    do_reset();

    // Single requester, fixed values from the directed scenario.
    step(1'b1, 4'd3, 8'h5A, 1'b0, 4'd0, 8'h00, 1'b0, "single");
    chk("single.lit_we", writeEnable, 1'b1);
    chk("single.lit_wa", writeAddress, 4'd3);
    chk("single.lit_wd", writeData, 8'h5A);
    chk("single.lit_gid", grantId, 1'b0);

    // Tie for four cycles alternates 0,1,0,1.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'(i + 1), 8'(8'h10 + i), 1'b1, 4'(i + 8), 8'(8'h20 + i), 1'b0, "tie");
      gids[i] = grantId;
    end
    chk("tie.order", gids, 4'b1010);
    chk("tie.conf", conflictCount, 8'd4);

    // Clear sequence with requester 0 waiting throughout.
    busy_cycles  = 0;
    clear_writes = 0;
    step(1'b1, 4'd9, 8'hC3, 1'b0, 4'd0, 8'h00, 1'b1, "clr_start");
    for (int i = 0; i < DEPTH; i++) begin
      if (clearBusy) busy_cycles++;
      step(1'b1, 4'd9, 8'hC3, 1'b0, 4'd0, 8'h00, (i == 3), "clr");
      if (writeEnable && writeData == 8'h00 && writeAddress == 4'(i)) clear_writes++;
    end
    chk("clr.busy_cycles", busy_cycles, DEPTH);
    chk("clr.writes", clear_writes, DEPTH);
    step(1'b1, 4'd9, 8'hC3, 1'b0, 4'd0, 8'h00, 1'b0, "clr_after");
    chk("clr_after.wa", writeAddress, 4'd9);

    // Reset in the middle of a clear aborts it.
    step(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b1, "abort_start");
    for (int i = 0; i < 7; i++) step(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b0, "abort_run");
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b0, "abort_idle");

    // Address 0 write.
    step(1'b1, 4'd0, 8'hFF, 1'b0, 4'd0, 8'h00, 1'b0, "zero");
`ifdef RF_ARB_ZERO_REG_EN
    chk("zero.lit_we", writeEnable, 1'b0);
`else
    chk("zero.lit_we", writeEnable, 1'b1);
    chk("zero.lit_wd", writeData, 8'hFF);
`endif

    // Randomized traffic with occasional clear pulses.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), 4'($urandom), 8'($urandom), 1'($urandom), 4'($urandom), 8'($urandom),
           ($urandom_range(0, 29) == 0), "rand");
    end

    // Conflict counter saturation.
    do_reset();
    for (int i = 0; i < 260; i++) begin
      step(1'b1, 4'($urandom), 8'($urandom), 1'b1, 4'($urandom), 8'($urandom), 1'b0, "sat");
    end
    chk("sat.lit_conf", conflictCount, 8'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
